// File: rtl/defines_pkg.sv
// Shared types and default sizes for the BDF schedule controller loader.
// Optional feature macro: CTRL_LOADER_CHKSUM_EN (checksum word after each schedule).
package defines_pkg;

  localparam int DEF_CTRL_WIDTH = 24;
  localparam int DEF_CTRL_DEPTH = 48;
  localparam int DEF_ITER_W     = 16;

  // CHK is only ever entered when the checksum feature is compiled in.
  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    PAD   = 3'd1,
    CHK   = 3'd2,
    ARMED = 3'd3,
    RUN   = 3'd4
  } ldr_state_e;

endpackage

// File: rtl/ctrl_xor_acc.sv
// Running XOR of the schedule words of one load; restarts on the first word.
module ctrl_xor_acc #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] acc
);

  // First word of a load replaces the sum, later words fold in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= clr ? data : (acc ^ data);
    end
  end

endmodule

// File: rtl/ctrl_loader.sv
// Write-side front end of the BDF schedule controller memory.
// Streams CTRL_DEPTH control words into the controller, then runs it for a
// whole number of iteration periods so its wr/rd address counters stay aligned.
// Optional feature macro: CTRL_LOADER_CHKSUM_EN (XOR checksum word, sticky err).
// Handshake: a word moves when cfg_valid && cfg_ready in the same cycle;
// cfg_ready never depends on cfg_valid, and a held word may wait indefinitely.
module ctrl_loader
  import defines_pkg::*;
#(
  parameter int CTRL_WIDTH = DEF_CTRL_WIDTH,
  parameter int CTRL_DEPTH = DEF_CTRL_DEPTH,
  parameter int ITER_W     = DEF_ITER_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CTRL_WIDTH-1:0] cfg_data,
  input  logic [ITER_W-1:0]     cfg_iters,
  input  logic                  go,
  input  logic                  abort,
  output logic [CTRL_WIDTH-1:0] ctrl_in,
  output logic                  load_ctrl,
  output logic                  start_ctrl,
  output logic                  stop_ctrl,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output ldr_state_e            dbg_state
);

  localparam int CW = $clog2(CTRL_DEPTH + 1);
  localparam logic [CW-1:0] LAST = CW'(CTRL_DEPTH - 1);

  ldr_state_e            state, state_n;
  logic [CW-1:0]         wcnt, wcnt_n;
  logic [CW-1:0]         pcnt, pcnt_n;
  logic [ITER_W-1:0]     icnt, icnt_n;
  logic [ITER_W-1:0]     iters, iters_n;
  logic                  drain, drain_n;
  logic [CTRL_WIDTH-1:0] ctrl_in_n;
  logic                  load_n, start_n, stop_n, err_n;
  logic                  accept;

`ifdef CTRL_LOADER_CHKSUM_EN
  logic [CTRL_WIDTH-1:0] acc;

  ctrl_xor_acc #(.WIDTH(CTRL_WIDTH)) u_xor_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (wcnt == '0),
    .en   (accept && (state == LOAD)),
    .data (cfg_data),
    .acc  (acc)
  );

  assign cfg_ready = ((state == LOAD) || (state == CHK)) && !abort;
`else
  assign cfg_ready = (state == LOAD) && !abort;
`endif

  assign accept    = cfg_valid && cfg_ready;
  assign dbg_state = state;

  // Next-state, counter and output decisions; everything is registered below.
  always_comb begin
    state_n   = state;
    wcnt_n    = wcnt;
    pcnt_n    = pcnt;
    icnt_n    = icnt;
    iters_n   = iters;
    drain_n   = drain;
    ctrl_in_n = ctrl_in;
    load_n    = 1'b0;
    start_n   = 1'b0;
    stop_n    = 1'b0;
    err_n     = err;
    case (state)
      LOAD: begin
        if (accept) begin
          ctrl_in_n = cfg_data;
          load_n    = 1'b1;
          err_n     = 1'b0;
          wcnt_n    = wcnt + CW'(1);
          if (wcnt == LAST) begin
`ifdef CTRL_LOADER_CHKSUM_EN
            state_n = CHK;
`else
            state_n = ARMED;
`endif
          end
        end else if (abort && (wcnt != '0)) begin
          state_n = PAD;
        end
      end
      // Fill the rest of the period with zero words so wr_addr lands on a boundary.
      PAD: begin
        ctrl_in_n = '0;
        load_n    = 1'b1;
        if (wcnt == LAST) begin
          state_n = LOAD;
          wcnt_n  = '0;
        end else begin
          wcnt_n = wcnt + CW'(1);
        end
      end
`ifdef CTRL_LOADER_CHKSUM_EN
      // Checksum word is consumed but never written to the controller.
      CHK: begin
        if (abort) begin
          state_n = LOAD;
          wcnt_n  = '0;
        end else if (accept) begin
          if (cfg_data == acc) begin
            state_n = ARMED;
          end else begin
            err_n   = 1'b1;
            state_n = LOAD;
            wcnt_n  = '0;
          end
        end
      end
`endif
      ARMED: begin
        if (abort) begin
          state_n = LOAD;
          wcnt_n  = '0;
        end else if (go) begin
          iters_n = cfg_iters;
          start_n = 1'b1;
          state_n = RUN;
          pcnt_n  = '0;
          icnt_n  = '0;
          drain_n = 1'b0;
        end
      end
      // stop_ctrl is decided one cycle ahead so it is high while pcnt is last.
      RUN: begin
        if (stop_ctrl) begin
          state_n = ARMED;
          drain_n = 1'b0;
        end else begin
          if (pcnt == LAST) begin
            pcnt_n = '0;
            icnt_n = icnt + ITER_W'(1);
          end else begin
            pcnt_n = pcnt + CW'(1);
          end
          drain_n = drain | abort;
          if ((pcnt_n == LAST) &&
              (drain_n || ((iters != '0) && (icnt_n == iters - ITER_W'(1))))) begin
            stop_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = LOAD;
        wcnt_n  = '0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= LOAD;
      wcnt       <= '0;
      pcnt       <= '0;
      icnt       <= '0;
      iters      <= '0;
      drain      <= 1'b0;
      ctrl_in    <= '0;
      load_ctrl  <= 1'b0;
      start_ctrl <= 1'b0;
      stop_ctrl  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      wcnt       <= wcnt_n;
      pcnt       <= pcnt_n;
      icnt       <= icnt_n;
      iters      <= iters_n;
      drain      <= drain_n;
      ctrl_in    <= ctrl_in_n;
      load_ctrl  <= load_n;
      start_ctrl <= start_n;
      stop_ctrl  <= stop_n;
      busy       <= (state_n == RUN);
      done       <= stop_n;
      err        <= err_n;
    end
  end

endmodule

// File: tb/tb_ctrl_loader.sv
// Self-checking bench for ctrl_loader with CTRL_DEPTH=4.
// Written words go through an expected queue; run timing is predicted from
// T (start cycle), the iteration count and the period length.
module tb_ctrl_loader;
  import defines_pkg::*;

  localparam int W  = 24;
  localparam int D  = 4;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [W-1:0]  cfg_data = '0;
  logic [IW-1:0] cfg_iters = '0;
  logic          go = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  ctrl_in;
  logic          load_ctrl, start_ctrl, stop_ctrl, busy, done, err;
  ldr_state_e    dbg_state;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  sb_word;
  int            n_checks = 0;
  int            n_pass = 0;
  int            load_cnt = 0;

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  ctrl_loader #(.CTRL_WIDTH(W), .CTRL_DEPTH(D), .ITER_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .cfg_iters  (cfg_iters),
    .go         (go),
    .abort      (abort),
    .ctrl_in    (ctrl_in),
    .load_ctrl  (load_ctrl),
    .start_ctrl (start_ctrl),
    .stop_ctrl  (stop_ctrl),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // Scoreboard: every memory write must match the next expected word.
  always @(negedge clk) begin
    if (rst && load_ctrl) begin
      load_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL write_unexpected: ctrl_in=%0h with no word expected", ctrl_in);
      end else begin
        sb_word = exp_q.pop_front();
        if (ctrl_in !== sb_word)
          $display("FAIL write_data: ctrl_in=%0h expected %0h", ctrl_in, sb_word);
        else
          n_pass++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({ctrl_in, load_ctrl, start_ctrl, stop_ctrl, busy, done, err} !== '0)
      $display("FAIL reset_outputs: got %0h expected 0",
               {ctrl_in, load_ctrl, start_ctrl, stop_ctrl, busy, done, err});
    else n_pass++;
    n_checks++;
    if (cfg_ready !== 1'b1 || dbg_state !== LOAD)
      $display("FAIL reset_ready: ready=%0b state=%0d expected 1/LOAD", cfg_ready, dbg_state);
    else n_pass++;
    rst = 1'b1;
    tick();
  endtask

  // Loads one full schedule from LOAD; ends in ARMED.
  task automatic load_schedule(input bit fixed, input bit gaps);
    logic [W-1:0] w;
    logic [W-1:0] x;
    int ready_bad;
    int c0;
    x = '0;
    ready_bad = 0;
    c0 = load_cnt;
    for (int i = 0; i < D; i++) begin
      if (gaps) begin
        cfg_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      w = fixed ? W'(i + 1) : W'($urandom);
      cfg_valid = 1'b1;
      cfg_data  = w;
      #1;
      if (cfg_ready !== 1'b1) ready_bad++;
      exp_q.push_back(w);
      x = x ^ w;
      tick();
    end
`ifdef CTRL_LOADER_CHKSUM_EN
    cfg_data = x;
    #1;
    if (cfg_ready !== 1'b1) ready_bad++;
    tick();
`endif
    cfg_valid = 1'b0;
    tick();
    n_checks++;
    if (ready_bad != 0) $display("FAIL load_ready: %0d words saw ready=0, expected 0", ready_bad);
    else n_pass++;
    n_checks++;
    if (dbg_state !== ARMED || cfg_ready !== 1'b0)
      $display("FAIL load_armed: state=%0d ready=%0b expected ARMED/0", dbg_state, cfg_ready);
    else n_pass++;
    // A word offered while armed must not be taken.
    cfg_valid = 1'b1;
    cfg_data  = W'($urandom);
    tick();
    tick();
    cfg_valid = 1'b0;
    n_checks++;
    if (load_cnt - c0 != D || exp_q.size() != 0)
      $display("FAIL load_count: writes=%0d left=%0d expected %0d/0", load_cnt - c0, exp_q.size(), D);
    else n_pass++;
  endtask

  // From ARMED: run iters periods with ignored go pulses; ends in ARMED.
  task automatic test_run(input int iters);
    int s, k_start, k_stop, n_start, n_stop, bad_busy, bad_done;
    s = iters * D - 1;
    k_start = -1; k_stop = -1; n_start = 0; n_stop = 0; bad_busy = 0; bad_done = 0;
    cfg_iters = IW'(iters);
    go = 1'b1;
    tick();
    go = 1'b0;
    cfg_iters = IW'($urandom);
    for (int k = 0; k <= s + 1; k++) begin
      if (start_ctrl === 1'b1) begin n_start++; if (k_start < 0) k_start = k; end
      if (stop_ctrl === 1'b1) begin n_stop++; if (k_stop < 0) k_stop = k; end
      if (busy !== (k <= s)) bad_busy++;
      if (done !== stop_ctrl) bad_done++;
      go = (k < s) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    n_checks++;
    if (k_start != 0 || n_start != 1)
      $display("FAIL run_start: first at T+%0d count %0d expected T+0 count 1", k_start, n_start);
    else n_pass++;
    n_checks++;
    if (k_stop != s || n_stop != 1)
      $display("FAIL run_stop: first at T+%0d count %0d expected T+%0d count 1", k_stop, n_stop, s);
    else n_pass++;
    n_checks++;
    if (bad_busy != 0 || bad_done != 0)
      $display("FAIL run_busy_done: busy errs %0d done errs %0d expected 0/0", bad_busy, bad_done);
    else n_pass++;
    n_checks++;
    if (dbg_state !== ARMED)
      $display("FAIL run_end_state: state=%0d expected ARMED", dbg_state);
    else n_pass++;
  endtask

  // From ARMED: unbounded run, abort in cycle T+a; stop only at a period end.
  task automatic test_abort_run(input int a);
    int exp_s, k_stop, bad_busy;
    exp_s = a + 1 + ((D - 1 - ((a + 1) % D)) % D);
    k_stop = -1;
    bad_busy = 0;
    cfg_iters = '0;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int k = 0; k <= exp_s + 2; k++) begin
      if (stop_ctrl === 1'b1 && k_stop < 0) k_stop = k;
      if (busy !== (k <= exp_s)) bad_busy++;
      abort = (k == a);
      tick();
    end
    abort = 1'b0;
    n_checks++;
    if (k_stop != exp_s)
      $display("FAIL drain_stop: stop at T+%0d expected T+%0d", k_stop, exp_s);
    else n_pass++;
    n_checks++;
    if (bad_busy != 0 || dbg_state !== ARMED)
      $display("FAIL drain_end: busy errs %0d state %0d expected 0/ARMED", bad_busy, dbg_state);
    else n_pass++;
  endtask

  task automatic test_armed_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    #1;
    n_checks++;
    if (dbg_state !== LOAD || cfg_ready !== 1'b1)
      $display("FAIL armed_abort: state=%0d ready=%0b expected LOAD/1", dbg_state, cfg_ready);
    else n_pass++;
    tick();
  endtask

  task automatic test_abort_empty();
    int c0;
    c0 = load_cnt;
    abort = 1'b1;
    #1;
    n_checks++;
    if (cfg_ready !== 1'b0) $display("FAIL abort_ready: ready=%0b expected 0", cfg_ready);
    else n_pass++;
    tick();
    abort = 1'b0;
    tick();
    tick();
    n_checks++;
    if (dbg_state !== LOAD || load_cnt != c0)
      $display("FAIL abort_empty: state=%0d writes=%0d expected LOAD/0", dbg_state, load_cnt - c0);
    else n_pass++;
  endtask

  // From LOAD: n words then abort; remaining slots are padded with zeros.
  task automatic test_pad(input int n);
    int c0;
    logic [W-1:0] w;
    c0 = load_cnt;
    for (int i = 0; i < n; i++) begin
      w = W'($urandom);
      cfg_valid = 1'b1;
      cfg_data  = w;
      exp_q.push_back(w);
      tick();
    end
    cfg_valid = 1'b0;
    abort = 1'b1;
    for (int i = n; i < D; i++) exp_q.push_back('0);
    tick();
    abort = 1'b0;
    repeat (D - n + 2) tick();
    n_checks++;
    if (load_cnt - c0 != D || exp_q.size() != 0)
      $display("FAIL pad_count: writes=%0d left=%0d expected %0d/0", load_cnt - c0, exp_q.size(), D);
    else n_pass++;
    n_checks++;
    if (dbg_state !== LOAD || cfg_ready !== 1'b1)
      $display("FAIL pad_end: state=%0d ready=%0b expected LOAD/1", dbg_state, cfg_ready);
    else n_pass++;
  endtask

  task automatic test_go_abort_same();
    go = 1'b1;
    abort = 1'b1;
    cfg_iters = 16'd1;
    tick();
    go = 1'b0;
    abort = 1'b0;
    tick();
    n_checks++;
    if (start_ctrl !== 1'b0 || busy !== 1'b0 || dbg_state !== LOAD)
      $display("FAIL go_abort: start=%0b busy=%0b state=%0d expected 0/0/LOAD",
               start_ctrl, busy, dbg_state);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    cfg_iters = '0;
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat ($urandom_range(1, 5)) tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({ctrl_in, load_ctrl, start_ctrl, stop_ctrl, busy, done, err} !== '0 || cfg_ready !== 1'b1)
      $display("FAIL reset_mid_run: outputs=%0h ready=%0b expected 0/1",
               {ctrl_in, load_ctrl, start_ctrl, stop_ctrl, busy, done, err}, cfg_ready);
    else n_pass++;
    rst = 1'b1;
    tick();
  endtask

`ifdef CTRL_LOADER_CHKSUM_EN
  task automatic test_chksum_bad();
    for (int i = 0; i < D; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = W'(i + 1);
      exp_q.push_back(W'(i + 1));
      tick();
    end
    cfg_data = W'(5);
    tick();
    cfg_valid = 1'b0;
    tick();
    n_checks++;
    if (err !== 1'b1 || dbg_state !== LOAD)
      $display("FAIL chk_bad: err=%0b state=%0d expected 1/LOAD", err, dbg_state);
    else n_pass++;
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    n_checks++;
    if (start_ctrl !== 1'b0 || dbg_state !== LOAD)
      $display("FAIL chk_go: start=%0b state=%0d expected 0/LOAD", start_ctrl, dbg_state);
    else n_pass++;
    load_schedule(1'b1, 1'b0);
    n_checks++;
    if (err !== 1'b0) $display("FAIL chk_clear: err=%0b expected 0", err);
    else n_pass++;
  endtask
`endif

  // Test sequence and report
  initial begin
    test_reset();
    load_schedule(1'b1, 1'b0);
    test_run(2);
    test_run($urandom_range(1, 3));
    test_abort_run(5);
    test_abort_run($urandom_range(1, 9));
    test_armed_abort();
    test_abort_empty();
    test_pad(1);
    test_pad($urandom_range(1, D - 1));
    load_schedule(1'b0, 1'b1);
    test_go_abort_same();
    load_schedule(1'b0, 1'b1);
    test_run(1);
    test_reset_mid_run();
`ifdef CTRL_LOADER_CHKSUM_EN
    test_chksum_bad();
    test_run(1);
`else
    n_checks++;
    if (err !== 1'b0) $display("FAIL err_tied: err=%0b expected 0", err);
    else n_pass++;
`endif
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL queue_drained: %0d words left, expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
